// File: rtl/zion_skid_pkg.sv
// Shared types and constants for the clear-capable skid buffer.

`ifndef ZION_SKID_PKG_SV
`define ZION_SKID_PKG_SV

// Instantiation wrapper: WIDTH follows the connected data signal.
`define ZION_CLR_SKID_BUF(iname, clk_s, rst_s, clr_s, ivld_s, ordy_s, idat_s, ovld_s, irdy_s, odat_s, ocnt_s) \
  zion_clr_skid_buf #(.WIDTH($bits(idat_s))) iname ( \
    .clk (clk_s),  \
    .rst (rst_s),  \
    .iClr(clr_s),  \
    .iVld(ivld_s), \
    .oRdy(ordy_s), \
    .iDat(idat_s), \
    .oVld(ovld_s), \
    .iRdy(irdy_s), \
    .oDat(odat_s), \
    .oCnt(ocnt_s)  \
  )

package zion_skid_pkg;

  // Entries the stage can hold (main + skid).
  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;

  // Encoded as {skid valid, main valid}; 2'b10 cannot occur.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } skid_state_e;

  // Occupancy implied by a state: main valid plus skid valid.
  function automatic logic [CNT_W-1:0] skid_occupancy(input skid_state_e s);
    logic [CNT_W-1:0] occ;
    occ = CNT_W'(s[1]) + CNT_W'(s[0]);
    return occ;
  endfunction

endpackage

`endif

// File: rtl/zion_clr_skid_buf.sv
// Two-entry valid/ready skid buffer with a synchronous flush. Both the
// forward path (oVld/oDat) and the backward path (oRdy) come from flops.

module zion_clr_skid_buf
  import zion_skid_pkg::*;
#(
  parameter int unsigned       WIDTH    = 8,
  parameter logic [WIDTH-1:0]  INI_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iClr,
  input  logic             iVld,
  output logic             oRdy,
  input  logic [WIDTH-1:0] iDat,
  output logic             oVld,
  input  logic             iRdy,
  output logic [WIDTH-1:0] oDat,
  output logic [1:0]       oCnt
);

  // Elaboration-time width check.
  if (WIDTH < 32'd1) begin : g_width_chk
`ifdef CHECK_ERR_EXIT
    $fatal(1, "zion_clr_skid_buf: WIDTH must be >= 1");
`else
    $error("zion_clr_skid_buf: WIDTH must be >= 1");
`endif
  end

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] mdat_q,  mdat_d;
  logic [WIDTH-1:0] sdat_q,  sdat_d;
  logic             rdy_q,   rdy_d;
  logic [1:0]       cnt_q,   cnt_d;

  logic acc;
  logic xfer;

  // Handshakes, evaluated against the registered outputs.
  always_comb begin
    acc  = iVld & rdy_q;
    xfer = state_q[0] & iRdy;
  end

  // Next-state and data-register update; clear overrides everything.
  always_comb begin
    state_d = state_q;
    mdat_d  = mdat_q;
    sdat_d  = sdat_q;

    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d = BUSY;
          mdat_d  = iDat;
        end
      end
      BUSY: begin
        if (acc && xfer) begin
          mdat_d = iDat;
        end else if (acc) begin
          state_d = FULL;
          sdat_d  = iDat;
        end else if (xfer) begin
          // Main register keeps the delivered value while empty.
          state_d = EMPTY;
        end
      end
      FULL: begin
        // oRdy is low here, so only the drain of the main entry matters.
        if (xfer) begin
          state_d = BUSY;
          mdat_d  = sdat_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (iClr) begin
      state_d = EMPTY;
      mdat_d  = INI_DATA;
      sdat_d  = INI_DATA;
    end

    // Ready and occupancy are registered copies of the next state.
    rdy_d = ~state_d[1];
    cnt_d = skid_occupancy(state_d);
  end

  // State, data and status registers; asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      mdat_q  <= INI_DATA;
      sdat_q  <= INI_DATA;
      rdy_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mdat_q  <= mdat_d;
      sdat_q  <= sdat_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oVld = state_q[0];
  assign oRdy = rdy_q;
  assign oDat = mdat_q;
  assign oCnt = cnt_q;

`ifndef SYNTHESIS
  // The {skid valid, main valid} = 10 encoding must never be reached.
  a_no_state_10 : assert property (@(posedge clk) disable iff (rst)
    2'(state_q) != 2'b10);

  // Occupancy never exceeds the two storage entries.
  a_cnt_bound : assert property (@(posedge clk) disable iff (rst)
    oCnt <= 2'(SKID_DEPTH));

  // Registered ready always mirrors a free skid slot.
  a_rdy_match : assert property (@(posedge clk) disable iff (rst)
    oRdy == ~state_q[1]);

  // A stalled output beat is held stable until taken or flushed.
  a_out_hold : assert property (@(posedge clk) disable iff (rst)
    (oVld && !iRdy && !iClr) |=> (oVld && $stable(oDat)));
`endif

endmodule

// File: tb/tb_zion_clr_skid_buf.sv
// Self-checking bench for zion_clr_skid_buf against a queue-based model.

module tb_zion_clr_skid_buf;

  localparam int unsigned W   = 8;
  localparam logic [7:0]  INI = 8'hA5;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       iClr = 1'b0;
  logic       iVld = 1'b0;
  logic       iRdy = 1'b0;
  logic [7:0] iDat = 8'h00;
  logic       oRdy;
  logic       oVld;
  logic [7:0] oDat;
  logic [1:0] oCnt;

  int checks   = 0;
  int failures = 0;

  // Model: the stage is a FIFO of at most two beats; when it is empty the
  // output shows the last value that left the head (or INI after flush).
  logic [7:0] mq[$];
  logic [7:0] stale = INI;

  zion_clr_skid_buf #(.WIDTH(W), .INI_DATA(INI)) dut (
    .clk (clk),
    .rst (rst),
    .iClr(iClr),
    .iVld(iVld),
    .oRdy(oRdy),
    .iDat(iDat),
    .oVld(oVld),
    .iRdy(iRdy),
    .oDat(oDat),
    .oCnt(oCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_dat();
    return (mq.size() > 0) ? mq[0] : stale;
  endfunction

  task automatic model_flush();
    mq.delete();
    stale = INI;
  endtask

  // Drive one cycle from a negedge, update the model at the posedge,
  // return at the following negedge where outputs are sampled.
  task automatic cycle(input logic vld, input logic [7:0] dat,
                       input logic rdy, input logic clr);
    logic acc;
    logic xfer;
    iVld = vld;
    iDat = dat;
    iRdy = rdy;
    iClr = clr;
    acc  = vld && (mq.size() < 2);
    xfer = (mq.size() > 0) && rdy;
    @(posedge clk);
    if (clr) begin
      model_flush();
    end else begin
      if (xfer) stale = mq.pop_front();
      if (acc)  mq.push_back(dat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if (oVld !== 1'b0) begin failures++; $display("FAIL reset_ovld: got %b want 0", oVld); end
    checks++; if (oRdy !== 1'b1) begin failures++; $display("FAIL reset_ordy: got %b want 1", oRdy); end
    checks++; if (oDat !== INI)  begin failures++; $display("FAIL reset_odat: got %h want %h", oDat, INI); end
    checks++; if (oCnt !== 2'd0) begin failures++; $display("FAIL reset_ocnt: got %0d want 0", oCnt); end
    model_flush();
    @(negedge clk);
    rst = 1'b0;

    // Fill to FULL, then reset asynchronously in the middle of a cycle.
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b1, 8'h6B, 1'b0, 1'b0);
    checks++; if (oCnt !== 2'd2) begin failures++; $display("FAIL prefull_cnt: got %0d want 2", oCnt); end
    iVld = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (oVld !== 1'b0) begin failures++; $display("FAIL midreset_ovld: got %b want 0", oVld); end
    checks++; if (oRdy !== 1'b1) begin failures++; $display("FAIL midreset_ordy: got %b want 1", oRdy); end
    checks++; if (oDat !== INI)  begin failures++; $display("FAIL midreset_odat: got %h want %h", oDat, INI); end
    checks++; if (oCnt !== 2'd0) begin failures++; $display("FAIL midreset_ocnt: got %0d want 0", oCnt); end
    model_flush();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i), 1'b1, 1'b0);
      checks++; if (oVld !== 1'b1) begin failures++; $display("FAIL stream_ovld[%0d]: got %b want 1", i, oVld); end
      checks++; if (oDat !== 8'(i)) begin failures++; $display("FAIL stream_odat[%0d]: got %h want %h", i, oDat, 8'(i)); end
      checks++; if (oRdy !== 1'b1) begin failures++; $display("FAIL stream_ordy[%0d]: got %b want 1", i, oRdy); end
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (oVld !== 1'b0) begin failures++; $display("FAIL stream_drain: oVld got %b want 0", oVld); end
  endtask

  task automatic test_backpressure();
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    checks++; if (oCnt !== 2'd1 || oRdy !== 1'b1 || oDat !== 8'h11) begin
      failures++; $display("FAIL bp_one: cnt=%0d rdy=%b dat=%h want 1/1/11", oCnt, oRdy, oDat); end
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    checks++; if (oRdy !== 1'b0) begin failures++; $display("FAIL bp_full_rdy: got %b want 0", oRdy); end
    checks++; if (oCnt !== 2'd2) begin failures++; $display("FAIL bp_full_cnt: got %0d want 2", oCnt); end
    checks++; if (oDat !== 8'h11) begin failures++; $display("FAIL bp_full_dat: got %h want 11", oDat); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (oVld !== 1'b1 || oDat !== 8'h22 || oCnt !== 2'd1) begin
      failures++; $display("FAIL bp_drain1: vld=%b dat=%h cnt=%0d want 1/22/1", oVld, oDat, oCnt); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (oVld !== 1'b0 || oCnt !== 2'd0 || oRdy !== 1'b1) begin
      failures++; $display("FAIL bp_drain2: vld=%b cnt=%0d rdy=%b want 0/0/1", oVld, oCnt, oRdy); end
  endtask

  task automatic test_clear_full();
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    checks++; if (oVld !== 1'b1 || oDat !== 8'h11) begin
      failures++; $display("FAIL clrfull_pre: vld=%b dat=%h want 1/11", oVld, oDat); end
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    checks++; if (oVld !== 1'b0) begin failures++; $display("FAIL clrfull_ovld: got %b want 0", oVld); end
    checks++; if (oCnt !== 2'd0) begin failures++; $display("FAIL clrfull_ocnt: got %0d want 0", oCnt); end
    checks++; if (oDat !== INI)  begin failures++; $display("FAIL clrfull_odat: got %h want %h", oDat, INI); end
    checks++; if (oRdy !== 1'b1) begin failures++; $display("FAIL clrfull_ordy: got %b want 1", oRdy); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (oVld !== 1'b0 || oDat === 8'h22) begin
        failures++; $display("FAIL clrfull_ghost[%0d]: vld=%b dat=%h want 0/%h", i, oVld, oDat, INI); end
    end
  endtask

  task automatic test_clear_acc();
    cycle(1'b1, 8'h30, 1'b0, 1'b0);
    checks++; if (oVld !== 1'b1 || oCnt !== 2'd1) begin
      failures++; $display("FAIL clracc_busy: vld=%b cnt=%0d want 1/1", oVld, oCnt); end
    cycle(1'b1, 8'h33, 1'b0, 1'b1);
    checks++; if (oVld !== 1'b0 || oCnt !== 2'd0 || oDat !== INI) begin
      failures++; $display("FAIL clracc_drop: vld=%b cnt=%0d dat=%h want 0/0/%h", oVld, oCnt, oDat, INI); end
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    checks++; if (oVld !== 1'b1 || oDat !== 8'h44 || oCnt !== 2'd1) begin
      failures++; $display("FAIL clracc_next: vld=%b dat=%h cnt=%0d want 1/44/1", oVld, oDat, oCnt); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (oVld !== 1'b0) begin failures++; $display("FAIL clracc_drain: vld=%b want 0", oVld); end
  endtask

  task automatic test_random();
    logic       vld, rdy, clr;
    logic [7:0] dat;
    logic       ev, er;
    logic [1:0] ec;
    int         errs;
    errs = 0;
    for (int n = 0; n < 10000; n++) begin
      vld = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 63) == 0);
      dat = 8'($urandom);
      cycle(vld, dat, rdy, clr);
      ev = (mq.size() > 0);
      er = (mq.size() < 2);
      ec = 2'(mq.size());
      checks++;
      if ({oVld, oRdy, oCnt} !== {ev, er, ec}) begin
        failures++;
        if (errs < 10) $display("FAIL rand_ctrl[%0d]: vld/rdy/cnt got %b/%b/%0d want %b/%b/%0d",
                                n, oVld, oRdy, oCnt, ev, er, ec);
        errs++;
      end
      checks++;
      if (oDat !== exp_dat()) begin
        failures++;
        if (errs < 10) $display("FAIL rand_dat[%0d]: got %h want %h", n, oDat, exp_dat());
        errs++;
      end
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (oVld !== 1'b0 || oCnt !== 2'd0) begin
      failures++; $display("FAIL rand_final: vld=%b cnt=%0d want 0/0", oVld, oCnt); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_clear_full();
    test_clear_acc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
